// File: rtl/multi_debounce.sv
// multi_debounce: per-channel button debouncer with press/release edge pulses
// and an optional auto-repeat generator while a channel is held high.
// All state is clocked by clock_10ms; reset is asynchronous and active high.
// The falling-edge pulse port is named release_pulse because "release" is a
// reserved word in the language.
module multi_debounce #(
  parameter int CHANNELS     = 4,
  parameter int STABLE_COUNT = 3,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic                clock_10ms,
  input  logic                reset,
  input  logic                debounceEnable,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic                any_press
);

  localparam int MCW  = $clog2(STABLE_COUNT + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HCW  = $clog2(RMAX + 1);

  localparam logic [MCW-1:0] MATCH_LAST = MCW'(STABLE_COUNT - 1);
  localparam logic [HCW-1:0] DELAY_LAST = HCW'(REPEAT_DELAY - 1);
  localparam logic [HCW-1:0] RATE_LAST  = HCW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  logic [CHANNELS-1:0] sync_a;
  logic [CHANNELS-1:0] sync_b;

  logic [MCW-1:0]      mcnt_q [CHANNELS];
  logic [MCW-1:0]      mcnt_d [CHANNELS];
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;

  rep_state_t          state_q [CHANNELS];
  rep_state_t          state_d [CHANNELS];
  logic [HCW-1:0]      hcnt_q  [CHANNELS];
  logic [HCW-1:0]      hcnt_d  [CHANNELS];
  logic [CHANNELS-1:0] repeat_d;

  // Two-flop synchroniser per channel; keeps running while filtering is off.
  always_ff @(posedge clock_10ms or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw_in;
      sync_b <= sync_a;
    end
  end

  // Mismatch filter: accept the synchronised level after STABLE_COUNT
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    level_d = level;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      mcnt_d[i] = '0;
      if (debounceEnable && (sync_b[i] != level[i])) begin
        if (mcnt_q[i] == MATCH_LAST) begin
          level_d[i] = sync_b[i];
        end else begin
          mcnt_d[i] = mcnt_q[i] + MCW'(1);
        end
      end
    end
    rise = level_d & ~level;
    fall = ~level_d & level;
  end

  // Mismatch counter registers.
  always_ff @(posedge clock_10ms or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        mcnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        mcnt_q[i] <= mcnt_d[i];
      end
    end
  end

  // Repeat FSM state and hold/rate counter registers.
  always_ff @(posedge clock_10ms or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        hcnt_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        hcnt_q[i]  <= hcnt_d[i];
      end
    end
  end

  // Repeat FSM next state. The counter reloads to zero on every pulse, so it
  // never has to wrap by overflow. A fall is taken from the same edge's next
  // level so no repeat pulse can land in the release cycle.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      state_d[i]  = state_q[i];
      hcnt_d[i]   = '0;
      repeat_d[i] = 1'b0;
      if ((REPEAT_EN == 0) || !debounceEnable) begin
        state_d[i] = IDLE;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (rise[i]) begin
              state_d[i] = HELD;
            end
          end
          HELD: begin
            if (fall[i]) begin
              state_d[i] = IDLE;
            end else if (hcnt_q[i] == DELAY_LAST) begin
              state_d[i]  = REPEAT;
              repeat_d[i] = 1'b1;
            end else begin
              hcnt_d[i] = hcnt_q[i] + HCW'(1);
            end
          end
          REPEAT: begin
            if (fall[i]) begin
              state_d[i] = IDLE;
            end else if (hcnt_q[i] == RATE_LAST) begin
              repeat_d[i] = 1'b1;
            end else begin
              hcnt_d[i] = hcnt_q[i] + HCW'(1);
            end
          end
          default: begin
            state_d[i] = IDLE;
          end
        endcase
      end
    end
  end

  // Registered outputs: level plus single-cycle event pulses.
  always_ff @(posedge clock_10ms or posedge reset) begin
    if (reset) begin
      level         <= '0;
      press         <= '0;
      release_pulse <= '0;
      repeat_pulse  <= '0;
      any_press     <= 1'b0;
    end else begin
      level         <= level_d;
      press         <= rise;
      release_pulse <= fall;
      repeat_pulse  <= repeat_d;
      any_press     <= |rise;
    end
  end

endmodule

// File: doc/multi_debounce.md
MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, legal range 1..16.
REQ-002 Parameter STABLE_COUNT, default 3: consecutive mismatch cycles required to accept a new level, minimum 1.
REQ-003 Parameter REPEAT_EN, default 1: 1 enables auto-repeat; 0 holds repeat_pulse at 0.
REQ-004 Parameter REPEAT_DELAY, default 50: cycles from a press pulse to the first repeat pulse, minimum 2.
REQ-005 Parameter REPEAT_RATE, default 10: cycles between successive repeat pulses, minimum 1.
REQ-006 Port clock_10ms  input  1: the single clock; all state updates on its rising edge.
REQ-007 Port reset  input  1: asynchronous, active-high reset.
REQ-008 Port debounceEnable  input  1: 1 = filtering active; 0 = filter frozen per REQ-019.
REQ-009 Port raw_in  input  CHANNELS: asynchronous raw button/switch levels, bit i = channel i.
REQ-010 Port level  output  CHANNELS: debounced, registered level per channel.
REQ-011 Port press  output  CHANNELS: one-cycle pulse on each accepted 0->1 transition of level.
REQ-012 Port release  output  CHANNELS: one-cycle pulse on each accepted 1->0 transition of level.
REQ-013 Port repeat_pulse  output  CHANNELS: one-cycle auto-repeat pulse while a channel is held high.
REQ-014 Port any_press  output  1: registered OR of all press bits, same cycle as press.

Function
REQ-015 Each raw_in bit SHALL pass through a two-flop synchroniser; only the second-flop output s[i] is used internally.
REQ-016 Per channel, a mismatch counter (width clog2(STABLE_COUNT+1)) SHALL increment on every edge where s[i] != level[i], and SHALL clear on any edge where s[i] == level[i].
REQ-017 On an edge where s[i] != level[i] and the counter equals STABLE_COUNT-1, level[i] SHALL take s[i] and the counter SHALL clear; a raw change sampled at edge N and held is therefore visible on level after edge N+STABLE_COUNT+1.
REQ-018 A glitch shorter than STABLE_COUNT synchronised cycles SHALL produce no change on level and no pulse.
REQ-019 While debounceEnable=0: synchronisers keep running; mismatch and repeat counters clear; level holds; press, release, repeat_pulse, any_press are 0; repeat FSM returns to IDLE.
REQ-020 press[i] (release[i]) SHALL be high for exactly the one cycle following the edge on which level[i] rises (falls); never both in the same cycle.
REQ-021 Per channel, the repeat FSM SHALL have states IDLE, HELD, REPEAT: IDLE->HELD on level rise (hold counter cleared); HELD->REPEAT when the hold counter reaches REPEAT_DELAY-1, emitting repeat_pulse; in REPEAT, emit repeat_pulse every REPEAT_RATE cycles.
REQ-022 The first repeat_pulse SHALL occur exactly REPEAT_DELAY cycles after the press pulse; subsequent ones at intervals of exactly REPEAT_RATE cycles; repeat_pulse SHALL never coincide with press.
REQ-023 Level fall in HELD or REPEAT SHALL force IDLE on the same edge; no repeat_pulse in or after the release cycle.
REQ-024 Hold/rate counters SHALL be sized for max(REPEAT_DELAY, REPEAT_RATE) and SHALL wrap only via explicit reload, never by overflow.
REQ-025 With REPEAT_EN=0 the FSM SHALL remain in IDLE and repeat_pulse SHALL be constant 0.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-027 reset=1 SHALL immediately (asynchronously) clear synchronisers, counters, level, press, release, repeat_pulse, any_press to 0 and all FSMs to IDLE.
REQ-028 Reset asserted mid-filter or mid-repeat SHALL discard partial counts; after deassertion, a held-high input SHALL require the full REQ-017 latency and generate a fresh press.

Verification (CHANNELS=4, STABLE_COUNT=3, REPEAT_DELAY=5, REPEAT_RATE=2)
REQ-029 raw_in[0] 0->1 sampled at edge 10, held -> level[0]=1 after edge 14; press[0] and any_press high for the cycle after edge 14 only.
REQ-030 raw_in[1] high for 2 cycles then low -> level[1], press[1], release[1] stay 0 throughout.
REQ-031 raw_in[2] held high 20 cycles -> first repeat_pulse[2] 5 cycles after press[2], then every 2 cycles; release[2] on drop, no repeat_pulse afterwards.
REQ-032 raw_in[0] and raw_in[3] rise on the same edge -> press[0] and press[3] in the same cycle, any_press single-cycle high.
REQ-033 debounceEnable=0 while raw_in[1] rises and is held -> level[1] stays 0; re-enable -> level[1]=1 exactly 3 cycles later with press[1].
REQ-034 reset pulsed during REPEAT on channel 2 with input still high -> all outputs 0 immediately; after release, new press[2] at full latency and repeat restarts from REPEAT_DELAY.
